// File: rtl/mandel_sched.sv
// rtl/mandel_sched.sv - raster-order work scheduler for a pool of mandelbrot units
module mandel_sched #(
    parameter int CORDW     = 16,
    parameter int FB_WIDTH  = 320,
    parameter int FB_HEIGHT = 180,
    parameter int FP_WIDTH  = 25,
    parameter int ITERW     = 8,
    parameter int UNITS     = 4
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       start,
    input  logic signed [FP_WIDTH-1:0] x_start,
    input  logic signed [FP_WIDTH-1:0] y_start,
    input  logic signed [FP_WIDTH-1:0] step,
    output logic [UNITS-1:0]           u_start,
    output logic signed [FP_WIDTH-1:0] u_re,
    output logic signed [FP_WIDTH-1:0] u_im,
    input  logic [UNITS-1:0]           u_done,
    input  logic [UNITS*ITERW-1:0]     u_iter,
    output logic                       pix_valid,
    input  logic                       pix_ready,
    output logic signed [CORDW-1:0]    pix_x,
    output logic signed [CORDW-1:0]    pix_y,
    output logic [ITERW-1:0]           pix_iter,
    output logic                       busy,
    output logic                       done
);
    localparam int PW = (UNITS > 1) ? $clog2(UNITS) : 1;
    localparam logic [CORDW-1:0] X_LAST = CORDW'(FB_WIDTH - 1);
    localparam logic [CORDW-1:0] Y_LAST = CORDW'(FB_HEIGHT - 1);
    localparam logic [PW-1:0]    P_LAST = PW'(UNITS - 1);

    typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} top_t;
    typedef enum logic [1:0] {U_IDLE, U_CALC, U_HOLD} unit_t;

    top_t                       st, st_nx;
    unit_t                      ust    [UNITS];
    logic [CORDW-1:0]           tag_x  [UNITS];
    logic [CORDW-1:0]           tag_y  [UNITS];
    logic [ITERW-1:0]           tag_it [UNITS];
    logic [CORDW-1:0]           x_cnt, y_cnt;
    logic signed [FP_WIDTH-1:0] fx, fy, x0, stp;
    logic                       issued_all;
    logic [PW-1:0]              disp_ptr, out_ptr, sel;

    logic                       pop, dispatch, disp_ok, hold_ok;
    logic [PW-1:0]              disp_idx, hold_idx;
    logic [UNITS-1:0]           idle_mask, hold_mask, pop_mask;

    assign pop      = pix_valid && pix_ready;
    assign dispatch = (st == S_RUN) && !issued_all && disp_ok;

    // The unit being popped this cycle must not be re-selected for output.
    always_comb begin
        idle_mask = '0;
        hold_mask = '0;
        pop_mask  = '0;
        for (int k = 0; k < UNITS; k++) begin
            idle_mask[k] = (ust[k] == U_IDLE);
            pop_mask[k]  = pop && (sel == PW'(k));
            hold_mask[k] = (ust[k] == U_HOLD) && !pop_mask[k];
        end
    end

    // Descending scan so the smallest offset from each pointer wins.
    always_comb begin
        int d, h;
        disp_ok  = 1'b0;
        disp_idx = '0;
        hold_ok  = 1'b0;
        hold_idx = '0;
        d = 0;
        h = 0;
        for (int i = UNITS - 1; i >= 0; i--) begin
            d = (int'(disp_ptr) + i) % UNITS;
            h = (int'(out_ptr) + i) % UNITS;
            if (idle_mask[d]) begin
                disp_ok  = 1'b1;
                disp_idx = PW'(d);
            end
            if (hold_mask[h]) begin
                hold_ok  = 1'b1;
                hold_idx = PW'(h);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) st <= S_IDLE;
        else     st <= st_nx;
    end

    // Finish is judged on the post-edge view so done follows the final pop directly.
    always_comb begin
        st_nx = st;
        case (st)
            S_IDLE: if (start) st_nx = S_RUN;
            S_RUN:  if (issued_all && (&(idle_mask | pop_mask)) && (!pix_valid || pop))
                        st_nx = S_DONE;
            S_DONE: st_nx = S_IDLE;
            default: st_nx = S_IDLE;
        endcase
    end

    always_comb begin
        busy    = (st == S_RUN);
        done    = (st == S_DONE);
        u_start = '0;
        u_re    = '0;
        u_im    = '0;
        if (dispatch) begin
            u_start[disp_idx] = 1'b1;
            u_re              = fx;
            u_im              = fy;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            x_cnt      <= '0;
            y_cnt      <= '0;
            fx         <= '0;
            fy         <= '0;
            x0         <= '0;
            stp        <= '0;
            issued_all <= 1'b0;
            disp_ptr   <= '0;
        end else if (st == S_IDLE && start) begin
            x0         <= x_start;
            stp        <= step;
            fx         <= x_start;
            fy         <= y_start;
            x_cnt      <= '0;
            y_cnt      <= '0;
            issued_all <= 1'b0;
        end else if (dispatch) begin
            disp_ptr <= (disp_idx == P_LAST) ? '0 : disp_idx + 1'b1;
            if (x_cnt == X_LAST && y_cnt == Y_LAST) issued_all <= 1'b1;
            if (x_cnt != X_LAST) begin
                x_cnt <= x_cnt + 1'b1;
                fx    <= fx + stp;
            end else begin
                x_cnt <= '0;
                fx    <= x0;
                y_cnt <= y_cnt + 1'b1;
                fy    <= fy + stp;
            end
        end
    end

    always_ff @(posedge clk) begin
        for (int k = 0; k < UNITS; k++) begin
            if (rst) begin
                ust[k] <= U_IDLE;
            end else begin
                case (ust[k])
                    U_IDLE: if (dispatch && disp_idx == PW'(k)) begin
                        ust[k]   <= U_CALC;
                        tag_x[k] <= x_cnt;
                        tag_y[k] <= y_cnt;
                    end
                    U_CALC: if (u_done[k]) begin
                        ust[k]    <= U_HOLD;
                        tag_it[k] <= u_iter[k*ITERW +: ITERW];
                    end
                    U_HOLD: if (pop_mask[k]) ust[k] <= U_IDLE;
                    default: ust[k] <= U_IDLE;
                endcase
            end
        end
    end

    // Output register only reloads when empty or accepted, keeping pix_* stable under backpressure.
    always_ff @(posedge clk) begin
        if (rst) begin
            pix_valid <= 1'b0;
            pix_x     <= '0;
            pix_y     <= '0;
            pix_iter  <= '0;
            sel       <= '0;
            out_ptr   <= '0;
        end else if (!pix_valid || pix_ready) begin
            pix_valid <= hold_ok;
            if (hold_ok) begin
                pix_x    <= tag_x[hold_idx];
                pix_y    <= tag_y[hold_idx];
                pix_iter <= tag_it[hold_idx];
                sel      <= hold_idx;
                out_ptr  <= (hold_idx == P_LAST) ? '0 : hold_idx + 1'b1;
            end
        end
    end
endmodule
